sext_stream_arbiter: RTL and testbench
======================================

SEXT_STREAM_ARBITER -- requirements
Module: sext_stream_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters; legal range 2..16.
REQ-002 Parameter IN_W, default 8: width of each signed input sample.
REQ-003 Parameter OUT_W, default 16: width of each sign-extended output sample; OUT_W >= IN_W, and OUT_W == IN_W means pass-through.
REQ-004 Parameter BURST, default 4: maximum number of consecutive accepted samples per grant; legal range 1..255.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  N_REQ  per-requester sample valid.
REQ-008 in_data  input  N_REQ*IN_W  packed samples; requester k occupies bits [k*IN_W +: IN_W].
REQ-009 in_ready  output  N_REQ  per-requester accept; at most one bit set in any cycle.
REQ-010 out_valid  output  1  output sample valid.
REQ-011 out_data  output  OUT_W  sign-extended sample.
REQ-012 out_chan  output  max(1,$clog2(N_REQ))  index of the source requester.
REQ-013 out_ready  input  1  downstream accept.

Function
REQ-014 A transfer on requester k occurs when in_valid[k] and in_ready[k] are both high at a clock edge; an output transfer occurs when out_valid and out_ready are both high.
REQ-015 FSM states: IDLE (no owner) and OWN (owner locked); the state is held in a registered owner index, a round-robin pointer ptr and a burst counter cnt.
REQ-016 In IDLE, all in_ready bits are 0; when any in_valid bit is high, the owner is the first requester with in_valid high, searching from ptr upward with modulo N_REQ wrap; the FSM moves to OWN on the next edge with cnt = 0.
REQ-017 In OWN, in_ready[owner] = (!out_valid || out_ready); every other in_ready bit is 0.
REQ-018 On an owner transfer: out_data <= {(OUT_W-IN_W) copies of sample MSB, sample}; out_chan <= owner; out_valid <= 1; cnt <= cnt+1.
REQ-019 Latency: a sample accepted at edge t is presented on the output from t+1 until the output transfer completes.
REQ-020 out_valid falls after an output transfer with no simultaneous owner transfer; a simultaneous output transfer and owner transfer keeps out_valid high with the new sample, giving full throughput.
REQ-021 Release OWN -> IDLE with ptr <= (owner+1) mod N_REQ when either: an owner transfer makes cnt reach BURST; or in_valid[owner] is low while in_ready[owner] is high.
REQ-022 While the output is stalled (out_valid && !out_ready), the owner is held and the idle-owner release does not trigger, so the output holds stable and no sample is dropped.
REQ-023 Re-arbitration costs exactly one IDLE cycle between grants; a lone active requester re-wins after that bubble.
REQ-024 in_valid changes on non-owners never affect the current grant.

Reset
REQ-025 While rst_n is low, independent of clk: state = IDLE, ptr = 0, cnt = 0, owner = 0, out_valid = 0, out_data = 0, out_chan = 0, and in_ready = 0.
REQ-026 Reset asserted mid-burst discards any pending output sample; after release the first grant searches from requester 0.
REQ-027 rst_n deassertion is synchronised externally; the block needs no internal synchroniser.

Structure
REQ-028 A shared package holds the FSM state enum (IDLE, OWN) and the default-parameter constants.
REQ-029 The round-robin search lives in one sub-module, rr_priority_picker: inputs are the request vector and ptr; outputs are the winner index and an any-request flag; it is purely combinational.
REQ-030 Sign extension is inline replication of the sample MSB into the output register; the datapath has no other arithmetic.

Verification (defaults N_REQ=4, IN_W=8, OUT_W=16, BURST=4)
REQ-031 Positive and negative samples, single requester: req1 sends 0x7F then 0x80 with out_ready=1 -> out_data 0x007F then 0xFF80, out_chan=1, each one cycle after its accept.
REQ-032 Burst limit: req0 is continuously valid and req2 is valid, out_ready=1 -> 4 samples from req0, one bubble, then 4 from req2, then back to req0.
REQ-033 Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data/out_chan stable, in_ready[owner]=0, no loss or duplication, and the burst resumes afterwards.
REQ-034 Early release: req3 drops in_valid after 2 samples -> return to IDLE with ptr=0, and next grant to the lowest-index valid requester at or above 0.
REQ-035 Wrap-around: ptr=3, only req0 and req2 are valid -> req0 is granted first.
REQ-036 Reset mid-burst: rst_n low while out_valid=1 -> out_valid, in_ready and out_data are 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/sext_stream_arbiter_pkg.sv
// Shared constants and FSM state encoding for the sign-extending stream arbiter.
package sext_stream_arbiter_pkg;

    localparam int DEF_N_REQ = 4;
    localparam int DEF_IN_W  = 8;
    localparam int DEF_OUT_W = 16;
    localparam int DEF_BURST = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Plain-vector views of the enum so state registers stay simple logic.
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_OWN  = OWN;

endpackage

// File: rtl/sext_stream_arbiter_rr_priority_picker.sv
// Combinational round-robin search: first asserted request at or above ptr, wrapping.
module rr_priority_picker #(
    parameter int N_REQ = 4,
    parameter int PW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [PW-1:0]    winner,
    output logic             any_req
);

    logic [PW:0]   sum_s;
    logic [PW-1:0] cand_s;
    logic          hit_s;
    logic          found_s;

    // Walk candidates ptr, ptr+1, ... modulo N_REQ and keep the first hit.
    always_comb begin
        winner  = {PW{1'b0}};
        found_s = 1'b0;
        sum_s   = {(PW+1){1'b0}};
        cand_s  = {PW{1'b0}};
        hit_s   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            sum_s   = {1'b0, ptr} + (PW+1)'(i);
            sum_s   = (sum_s >= (PW+1)'(N_REQ)) ? (sum_s - (PW+1)'(N_REQ)) : sum_s;
            cand_s  = sum_s[PW-1:0];
            hit_s   = !found_s && req[cand_s];
            winner  = hit_s ? cand_s : winner;
            found_s = found_s | hit_s;
        end
        any_req = |req;
    end

endmodule

// File: rtl/sext_stream_arbiter.sv
// N-way round-robin stream arbiter with burst limit; the granted sample is sign-extended into a registered output.
module sext_stream_arbiter
    import sext_stream_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int BURST = DEF_BURST
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [N_REQ-1:0]                       in_valid,
    input  logic [N_REQ*IN_W-1:0]                  in_data,
    output logic [N_REQ-1:0]                       in_ready,
    output logic                                   out_valid,
    output logic [OUT_W-1:0]                       out_data,
    output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] out_chan,
    input  logic                                   out_ready
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(BURST + 1);

    logic [0:0]       state_r;
    logic [PW-1:0]    owner_r;
    logic [PW-1:0]    ptr_r;
    logic [CW-1:0]    cnt_r;
    logic             out_valid_r;
    logic [OUT_W-1:0] out_data_r;
    logic [PW-1:0]    out_chan_r;

    logic [PW-1:0]    win_s;
    logic             any_s;
    logic             can_out_s;
    logic             own_valid_s;
    logic             own_xfer_s;
    logic             burst_done_s;
    logic             release_s;
    logic [CW-1:0]    cnt_inc_s;
    logic [PW-1:0]    next_ptr_s;
    logic [N_REQ-1:0] in_ready_s;
    logic [IN_W-1:0]  sample_s;
    logic [OUT_W-1:0] ext_s;

    rr_priority_picker #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_picker (
        .req     (in_valid),
        .ptr     (ptr_r),
        .winner  (win_s),
        .any_req (any_s)
    );

    // Grant handshake, release decision and next round-robin pointer.
    always_comb begin
        can_out_s    = !out_valid_r || out_ready;
        own_valid_s  = in_valid[owner_r];
        cnt_inc_s    = cnt_r + CW'(1);
        burst_done_s = (cnt_inc_s == CW'(BURST));
        in_ready_s   = {N_REQ{1'b0}};
        if (state_r == ST_OWN) begin
            in_ready_s[owner_r] = can_out_s;
        end else begin
            in_ready_s = {N_REQ{1'b0}};
        end
        own_xfer_s = (state_r == ST_OWN) && can_out_s && own_valid_s;
        // A stalled output keeps in_ready low, which also blocks the idle-owner release.
        release_s  = (state_r == ST_OWN) && can_out_s && (!own_valid_s || burst_done_s);
        if (owner_r == PW'(N_REQ - 1)) begin
            next_ptr_s = {PW{1'b0}};
        end else begin
            next_ptr_s = owner_r + PW'(1);
        end
    end

    // Select the owner's lane from the packed input bus.
    always_comb begin
        sample_s = {IN_W{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            sample_s = (owner_r == PW'(k)) ? in_data[k*IN_W +: IN_W] : sample_s;
        end
    end

    if (OUT_W > IN_W) begin : g_ext
        assign ext_s = {{(OUT_W-IN_W){sample_s[IN_W-1]}}, sample_s};
    end else begin : g_pass
        assign ext_s = sample_s;
    end

    // Arbitration FSM: owner lock, burst counting and pointer advance on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            owner_r <= {PW{1'b0}};
            ptr_r   <= {PW{1'b0}};
            cnt_r   <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        state_r <= ST_OWN;
                        owner_r <= win_s;
                        cnt_r   <= {CW{1'b0}};
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_OWN: begin
                    if (own_xfer_s) begin
                        cnt_r <= cnt_inc_s;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    if (release_s) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= next_ptr_s;
                    end else begin
                        state_r <= ST_OWN;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Output register: load on owner transfer, drain on downstream accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {OUT_W{1'b0}};
            out_chan_r  <= {PW{1'b0}};
        end else if (own_xfer_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= ext_s;
            out_chan_r  <= owner_r;
        end else if (out_valid_r && out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;

endmodule

// File: tb/tb_sext_stream_arbiter.sv
// Randomized and directed bench: transaction-level arbiter model plus an output scoreboard.
module tb_sext_stream_arbiter;

    localparam int N     = 4;
    localparam int IW    = 8;
    localparam int OW    = 16;
    localparam int BURST = 4;

    typedef struct packed {
        logic [7:0] d;
        int         rc;
    } ent_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    in_valid;
    logic [N*IW-1:0] in_data;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [OW-1:0]   out_data;
    logic [1:0]      out_chan;
    logic            out_ready;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    ent_t        src_q[N][$];
    logic [17:0] exp_q[$];
    int          chan_log[$];
    logic [15:0] data_log[$];
    int          exp_chans[$];

    int m_state, m_owner, m_ptr, m_cnt;
    bit m_ov;

    sext_stream_arbiter #(
        .N_REQ (N),
        .IN_W  (IW),
        .OUT_W (OW),
        .BURST (BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] sext(input logic [7:0] x);
        int v;
        v = int'(x);
        if (v > 127) v = v - 256;
        return v[15:0];
    endfunction

    task automatic push(input int k, input logic [7:0] d, input int rc);
        ent_t e;
        e.d  = d;
        e.rc = rc;
        src_q[k].push_back(e);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_owner = 0;
        m_ptr   = 0;
        m_cnt   = 0;
        m_ov    = 1'b0;
    endtask

    task automatic model_release();
        m_state = 0;
        m_ptr   = (m_owner + 1) % N;
    endtask

    // One clock: drive sources at negedge, check in_ready/out_valid, advance model.
    task automatic step(input logic ordy);
        logic [N-1:0]    iv;
        logic [N*IW-1:0] dat;
        logic [N-1:0]    er;
        bit              acc;
        bit              got;
        @(negedge clk);
        iv = '0;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0 && cyc >= src_q[k][0].rc) begin
                iv[k] = 1'b1;
                dat[k*IW +: IW] = src_q[k][0].d;
            end else begin
                dat[k*IW +: IW] = 8'($urandom);
            end
        end
        in_valid  = iv;
        in_data   = dat;
        out_ready = ordy;
        #1;
        er = '0;
        if (m_state == 1 && (!m_ov || ordy)) er[m_owner] = 1'b1;
        check("in_ready", 32'(in_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        acc = (m_state == 1) && er[m_owner] && iv[m_owner];
        if (m_state == 0) begin
            got = 1'b0;
            for (int j = 0; j < N; j++) begin
                int k;
                k = (m_ptr + j) % N;
                if (!got && iv[k]) begin
                    got     = 1'b1;
                    m_owner = k;
                end
            end
            if (got) begin
                m_state = 1;
                m_cnt   = 0;
            end
        end else if (er[m_owner]) begin
            if (iv[m_owner]) begin
                m_cnt++;
                exp_q.push_back({2'(m_owner), sext(src_q[m_owner][0].d)});
                void'(src_q[m_owner].pop_front());
                if (m_cnt == BURST) model_release();
            end else begin
                model_release();
            end
        end
        if (acc) m_ov = 1'b1;
        else if (m_ov && ordy) m_ov = 1'b0;
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        for (int k = 0; k < N; k++) src_q[k].delete();
        exp_q.delete();
        chan_log.delete();
        data_log.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    function automatic bit busy();
        bit b;
        b = m_ov || (exp_q.size() > 0);
        for (int k = 0; k < N; k++) b = b || (src_q[k].size() > 0);
        return b;
    endfunction

    // Run until all sources and the output are empty; out_ready low during [lo,hi).
    task automatic run(input string name, input int lo, input int hi, input int budget);
        int i;
        i = 0;
        while (busy() && i < budget) begin
            step(!(cyc >= lo && cyc < hi));
            i++;
        end
        repeat (2) step(1'b1);
        check({"done_", name}, 32'(busy()), 32'd0);
    endtask

    task automatic check_chans(input string name);
        check({name, "_count"}, chan_log.size(), exp_chans.size());
        for (int i = 0; i < exp_chans.size() && i < chan_log.size(); i++)
            check({name, "_chan"}, chan_log[i], exp_chans[i]);
    endtask

    // Output monitor: scoreboard pop on every output transfer, stability while stalled.
    initial begin
        bit          prev_stall;
        logic [15:0] prev_data;
        logic [1:0]  prev_chan;
        logic [17:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_chan  = '0;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n) begin
                if (prev_stall && out_valid) begin
                    check("stall_data", 32'(out_data), 32'(prev_data));
                    check("stall_chan", 32'(out_chan), 32'(prev_chan));
                end
                if (out_valid && out_ready) begin
                    check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_data", 32'(out_data), 32'(e[15:0]));
                        check("sb_chan", 32'(out_chan), 32'(e[17:16]));
                    end
                    chan_log.push_back(int'(out_chan));
                    data_log.push_back(out_data);
                end
                prev_stall = out_valid && !out_ready;
                prev_data  = out_data;
                prev_chan  = out_chan;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_chan", 32'(out_chan), 32'd0);

        // Positive and negative samples through requester 1.
        apply_reset();
        push(1, 8'h7F, 0);
        push(1, 8'h80, 0);
        run("sext", 0, 0, 50);
        exp_chans = '{1, 1};
        check_chans("sext");
        if (data_log.size() == 2) begin
            check("sext_pos", 32'(data_log[0]), 32'h007F);
            check("sext_neg", 32'(data_log[1]), 32'hFF80);
        end else begin
            check("sext_log", data_log.size(), 2);
        end

        // Burst limit alternation between requesters 0 and 2.
        apply_reset();
        for (int i = 0; i < 8; i++) push(0, 8'($urandom), 0);
        for (int i = 0; i < 4; i++) push(2, 8'($urandom), 0);
        run("burst", 0, 0, 100);
        exp_chans = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0};
        check_chans("burst");

        // Backpressure for five cycles mid-burst.
        apply_reset();
        for (int i = 0; i < 6; i++) push(0, 8'($urandom), 0);
        run("stall", 3, 8, 100);
        exp_chans = '{0, 0, 0, 0, 0, 0};
        check_chans("stall");

        // Early release by requester 3, then grant from pointer 0.
        apply_reset();
        push(3, 8'h11, 0);
        push(3, 8'h22, 0);
        push(1, 8'h33, 6);
        push(2, 8'h44, 6);
        run("early", 0, 0, 100);
        exp_chans = '{3, 3, 1, 2};
        check_chans("early");

        // Wrap-around: pointer lands on 3 with requesters 0 and 2 pending.
        apply_reset();
        push(2, 8'h55, 0);
        push(2, 8'h66, 6);
        push(0, 8'h77, 6);
        run("wrap", 0, 0, 100);
        exp_chans = '{2, 0, 2};
        check_chans("wrap");

        // Asynchronous reset while an output sample is pending.
        apply_reset();
        for (int i = 0; i < 4; i++) push(0, 8'hC0 + 8'(i), 0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_out_data", 32'(out_data), 32'd0);

        // Randomized traffic with random backpressure.
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() < 3 && $urandom_range(0, 2) == 0)
                    push(k, 8'($urandom), cyc + int'($urandom_range(0, 3)));
            end
            step($urandom_range(0, 3) != 0);
        end
        run("random", 0, 0, 500);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
